// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_arbiter
// Purpose  : Clocked phase controller for a four-approach intersection.
//            Shares one green phase among N/E/S/W. It either runs a timed
//            round-robin (fixed mode) or grants green to sensor requesters
//            within min/max green limits (actuated mode).
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            mode        - 0 fixed round-robin, 1 actuated (sampled on ALL_RED exit)
//            req[3:0]    - vehicle present: [3]=N [2]=E [1]=S [0]=W
//            lightout    - lamps {G,Y,R} x N,E,S,W (N in [11:9])
//            grant       - current/last served approach 0=N 1=E 2=S 3=W
//            phase       - 0 ALL_RED, 1 GREEN, 2 YELLOW
//            phase_start - one-cycle pulse on the first cycle of each phase
// Revision : 1.0  initial release
// ============================================================================
module traffic_phase_arbiter #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int CNT_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic [3:0]  req,
   output logic [11:0] lightout,
   output logic [1:0]  grant,
   output logic [1:0]  phase,
   output logic        phase_start
);

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] c_gmin_last   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] c_gmax_last   = CNT_W'(GREEN_MAX - 1);
   localparam logic [11:0]      c_all_red     = 12'b001_001_001_001;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_mode_q;
   logic             w_mode_nxt;
   logic [1:0]       w_grant_nxt;
   logic [1:0]       w_idx;
   logic [1:0]       w_pick;
   logic             w_found;
   logic             w_req_own;
   logic             w_other;
   logic             w_green_exit;
   logic             w_enter;
   logic [11:0]      w_lamp_nxt;

   // Request bits run N..W from bit 3 down, approach indices run N..W from 0
   // up, so the request bit of approach g is req[3-g], i.e. req[~g].
   always_comb begin
      w_req_own = req[~grant];
      w_other   = |(req & ~(4'b1000 >> grant));
      w_found   = 1'b0;
      w_pick    = grant;
      w_idx     = grant;
      // Walk offsets from farthest to nearest so the nearest requester
      // (grant+1 first, grant itself last) is the one that sticks.
      for (int i = 4; i >= 1; i--) begin
         w_idx = grant + 2'(i);
         if (req[~w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
      w_green_exit = (r_cnt >= c_gmin_last) && w_other &&
                     (!w_req_own || (r_cnt == c_gmax_last));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = grant;
      w_mode_nxt  = r_mode_q;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_enter     = 1'b0;
      case (r_state)
         ALL_RED: begin
            if (r_cnt == c_allred_last) begin
               if (!mode) begin
                  w_grant_nxt = grant + 2'd1;
                  w_state_nxt = GREEN;
                  w_mode_nxt  = 1'b0;
                  w_enter     = 1'b1;
               end else if (w_found) begin
                  w_grant_nxt = w_pick;
                  w_state_nxt = GREEN;
                  w_mode_nxt  = 1'b1;
                  w_enter     = 1'b1;
               end else begin
                  // Actuated with nobody waiting: rest here, re-check each cycle.
                  w_cnt_nxt = r_cnt;
               end
            end
         end
         GREEN: begin
            if (!r_mode_q) begin
               if (r_cnt == c_gmax_last) begin
                  w_state_nxt = YELLOW;
                  w_enter     = 1'b1;
               end
            end else if (w_green_exit) begin
               w_state_nxt = YELLOW;
               w_enter     = 1'b1;
            end else if (r_cnt == c_gmax_last) begin
               // Uncontested actuated green: counter saturates.
               w_cnt_nxt = r_cnt;
            end
         end
         YELLOW: begin
            if (r_cnt == c_yellow_last) begin
               w_state_nxt = ALL_RED;
               w_enter     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ALL_RED;
            w_enter     = 1'b1;
         end
      endcase
      if (w_enter) begin
         w_cnt_nxt = '0;
      end
   end

   // Lamps are derived from the next state so they change on the same edge.
   always_comb begin
      w_lamp_nxt = c_all_red;
      for (int a = 0; a < 4; a++) begin
         if (2'(a) == w_grant_nxt) begin
            if (w_state_nxt == GREEN) begin
               w_lamp_nxt[3*(3-a) +: 3] = 3'b100;
            end else if (w_state_nxt == YELLOW) begin
               w_lamp_nxt[3*(3-a) +: 3] = 3'b010;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ALL_RED;
         r_cnt       <= '0;
         r_mode_q    <= 1'b0;
         grant       <= 2'd3;
         lightout    <= c_all_red;
         phase       <= 2'd0;
         phase_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mode_q    <= w_mode_nxt;
         grant       <= w_grant_nxt;
         lightout    <= w_lamp_nxt;
         phase       <= w_state_nxt;
         phase_start <= w_enter;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_arbiter
// Purpose  : Self-checking bench for traffic_phase_arbiter. Stimulus pushes
//            the expected post-edge outputs into a queue; a monitor pops one
//            entry per clock and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_arbiter;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [3:0]  req;
   logic [11:0] lightout;
   logic [1:0]  grant;
   logic [1:0]  phase;
   logic        phase_start;

   typedef struct packed {
      logic [11:0] lo;
      logic [1:0]  g;
      logic [1:0]  ph;
      logic        ps;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   traffic_phase_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .req         (req),
      .lightout    (lightout),
      .grant       (grant),
      .phase       (phase),
      .phase_start (phase_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] lamp(input int g, input int ph);
      logic [11:0] r;
      r = 12'b001_001_001_001;
      if (ph == 1) r[3*(3-g) +: 3] = 3'b100;
      if (ph == 2) r[3*(3-g) +: 3] = 3'b010;
      return r;
   endfunction

   // Monitor: one expected entry per rising edge while out of reset.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         n_checks++;
         if ({lightout, grant, phase, phase_start} !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got lightout=%b grant=%0d phase=%0d ps=%b, want lightout=%b grant=%0d phase=%0d ps=%b",
                     $time, lightout, grant, phase, phase_start, e.lo, e.g, e.ph, e.ps);
         end
      end
   end

   // Drive inputs at a falling edge and queue what must appear after the next rising edge.
   task automatic step(input logic m, input logic [3:0] r, input int g, input int ph, input logic ps);
      exp_t e;
      mode = m;
      req  = r;
      e.lo = lamp(g, ph);
      e.g  = 2'(g);
      e.ph = 2'(ph);
      e.ps = ps;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run_phase(input logic m, input logic [3:0] r, input int g, input int ph,
                            input int n, input logic ps0);
      for (int i = 0; i < n; i++) step(m, r, g, ph, (i == 0) ? ps0 : 1'b0);
   endtask

   task automatic check_now(input string name, input logic [16:0] got, input logic [16:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   // Assert reset between clock edges and check outputs asynchronously.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_now("async_reset", {lightout, grant, phase, phase_start},
                {12'b001_001_001_001, 2'd3, 2'd0, 1'b0});
      q.delete();
      @(negedge clk);
      check_now("held_reset", {lightout, grant, phase, phase_start},
                {12'b001_001_001_001, 2'd3, 2'd0, 1'b0});
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      mode  = 1'b0;
      req   = 4'b0000;
      @(negedge clk);

      // Fixed round-robin: full 60-cycle rotation, then N again.
      do_reset();
      step(0, 4'b0000, 3, 0, 0);
      step(0, 4'b0000, 0, 1, 1);
      check_now("first_n_green", {5'd0, lightout}, {5'd0, 12'b100_001_001_001});
      run_phase(0, 4'b0000, 0, 1, 9, 0);
      run_phase(0, 4'b0000, 0, 2, 3, 1);
      check_now("n_yellow_lamps", {5'd0, lightout}, {5'd0, 12'b010_001_001_001});
      run_phase(0, 4'b0000, 0, 0, 2, 1);
      for (int k = 1; k < 4; k++) begin
         run_phase(0, 4'b0000, k, 1, 10, 1);
         run_phase(0, 4'b0000, k, 2, 3, 1);
         run_phase(0, 4'b0000, k, 0, 2, 1);
      end
      run_phase(0, 4'b0000, 0, 1, 10, 1);

      // Actuated, no requests: rest in all-red, then W asks.
      do_reset();
      step(1, 4'b0000, 3, 0, 0);
      run_phase(1, 4'b0000, 3, 0, 20, 0);
      step(1, 4'b0001, 3, 1, 1);
      run_phase(1, 4'b0001, 3, 1, 14, 0);

      // Actuated: N held, S joins at green cycle 1; E is skipped.
      do_reset();
      step(1, 4'b1000, 3, 0, 0);
      step(1, 4'b1000, 0, 1, 1);
      run_phase(1, 4'b1010, 0, 1, 9, 0);
      run_phase(1, 4'b1010, 0, 2, 3, 1);
      run_phase(1, 4'b1010, 0, 0, 2, 1);
      run_phase(1, 4'b1010, 2, 1, 10, 1);

      // Actuated: N drops its request at once, green ends at GREEN_MIN.
      do_reset();
      step(1, 4'b1000, 3, 0, 0);
      step(1, 4'b1000, 0, 1, 1);
      run_phase(1, 4'b0010, 0, 1, 3, 0);
      run_phase(1, 4'b0010, 0, 2, 3, 1);
      run_phase(1, 4'b0010, 0, 0, 2, 1);
      run_phase(1, 4'b0010, 2, 1, 14, 1);

      // Actuated fairness with everyone requesting.
      do_reset();
      step(1, 4'b1111, 3, 0, 0);
      for (int k = 0; k < 4; k++) begin
         run_phase(1, 4'b1111, k, 1, 10, 1);
         run_phase(1, 4'b1111, k, 2, 3, 1);
         run_phase(1, 4'b1111, k, 0, 2, 1);
      end
      run_phase(1, 4'b1111, 0, 1, 3, 1);

      // Mode flip mid-green keeps the latched fixed mode, then rests.
      do_reset();
      step(0, 4'b0000, 3, 0, 0);
      run_phase(0, 4'b0000, 0, 1, 10, 1);
      run_phase(0, 4'b0000, 0, 2, 3, 1);
      run_phase(0, 4'b0000, 0, 0, 2, 1);
      step(0, 4'b0000, 1, 1, 1);
      run_phase(1, 4'b0000, 1, 1, 9, 0);
      run_phase(1, 4'b0000, 1, 2, 3, 1);
      run_phase(1, 4'b0000, 1, 0, 2, 1);
      run_phase(1, 4'b0000, 1, 0, 4, 0);

      // Reset asserted in the middle of a yellow.
      do_reset();
      step(0, 4'b0000, 3, 0, 0);
      run_phase(0, 4'b0000, 0, 1, 10, 1);
      run_phase(0, 4'b0000, 0, 2, 2, 1);
      do_reset();
      step(0, 4'b0000, 3, 0, 0);
      step(0, 4'b0000, 0, 1, 1);

      @(negedge clk);
      check_now("queue_drained", 17'(q.size()), 17'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
